// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests, buffers
// responses in a small FIFO for decode, and squashes in-flight work on redirect.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [6:0]      id_opcode
);
    localparam int unsigned     PW      = $clog2(DEPTH);
    localparam int unsigned     CW      = PW + 1;
    localparam logic [CW:0]     DEPTH_L = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   pcq_rd;
    logic [PW-1:0]   pcq_wr;
    logic [XLEN-1:0] fifo_data [DEPTH];
    logic [XLEN-1:0] fifo_pc   [DEPTH];
    logic [XLEN-1:0] pcq       [DEPTH];

    logic          req_fire;
    logic          rsp_fire;
    logic          push;
    logic          pop;
    logic [CW-1:0] outstanding_next;

    always_comb begin
        imem_req_valid   = !rst && !redirect_valid
                           && (({1'b0, outstanding} + {1'b0, count}) < DEPTH_L);
        imem_req_addr    = pc;
        id_valid         = (count != '0);
        id_instr         = id_valid ? fifo_data[rd_ptr] : NOP;
        id_pc            = id_valid ? fifo_pc[rd_ptr] : '0;
        id_opcode        = id_instr[6:0];
        req_fire         = imem_req_valid && imem_req_ready;
        // Responses with nothing outstanding are stray and must not touch state.
        rsp_fire         = imem_rsp_valid && (outstanding != '0);
        push             = rsp_fire && (drop == '0) && !redirect_valid;
        pop              = id_valid && id_ready;
        outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            // The PC queue tracks every in-flight fetch, stale or not, so it is
            // never flushed by redirect; dropped responses retire their entry too.
            if (rsp_fire) pcq_rd <= pcq_rd + 1'b1;
            if (req_fire) pcq_wr <= pcq_wr + 1'b1;
            if (redirect_valid) begin
                pc     <= redirect_pc;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                drop   <= outstanding_next;
            end else begin
                if (req_fire) pc <= pc + XLEN'(4);
                if (rsp_fire && (drop != '0)) drop <= drop - 1'b1;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && req_fire) pcq[pcq_wr] <= pc;
        if (!rst && push) begin
            fifo_data[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]   <= pcq[pcq_rd];
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed corner sequences,
// and a randomized run against a queue-based model of the fetch stream.
module tb_fetch_unit;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_instr, id_pc;
    logic [6:0]  id_opcode;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_opcode(id_opcode)
    );

    // Memory model: in-order pending requests, each tagged with the fetch epoch.
    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        int unsigned epoch;
        bit          orphan;
    } mreq_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    typedef struct {
        bit          rst;
        bit          exp_rv;
        logic [31:0] exp_addr;
        bit          exp_idv;
        logic [31:0] exp_pc;
    } vec_t;

    mreq_t       memq[$];
    ent_t        bufq[$];
    logic [31:0] popped[$];
    logic [31:0] req_log[$];
    logic [31:0] mpc = RESET_PC;
    int unsigned epoch = 0, cyc = 0, last_due = 0;
    int unsigned lat_min = 1, lat_max = 1;
    int          checks = 0, failures = 0;
    bit          s_rv, s_idv;
    logic [31:0] s_addr, s_pc, s_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit r, input bit rv, input logic [31:0] rpc,
                        input bit idr, input bit rqr);
        bit          rsp_now, exp_rv, exp_idv, fire, pop;
        int unsigned inflight, lat, due;
        logic [31:0] exp_instr, exp_pc;
        mreq_t       m;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = idr;
        imem_req_ready = rqr;
        rsp_now        = (memq.size() != 0) && (memq[0].due <= cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? (memq[0].addr ^ KEY) : 32'h0;
        #4;
        inflight = 0;
        foreach (memq[i]) if (!memq[i].orphan) inflight++;
        exp_rv    = !r && !rv && ((inflight + bufq.size()) < DEPTH);
        exp_idv   = bufq.size() != 0;
        exp_instr = exp_idv ? bufq[0].instr : NOP;
        exp_pc    = exp_idv ? bufq[0].pc : 32'h0;
        s_rv = imem_req_valid; s_addr = imem_req_addr;
        s_idv = id_valid; s_pc = id_pc; s_instr = id_instr;
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        chk("req_addr", imem_req_addr, mpc);
        chk("id_valid", {31'b0, id_valid}, {31'b0, exp_idv});
        chk("id_instr", id_instr, exp_instr);
        chk("id_pc", id_pc, exp_pc);
        chk("id_opcode", {25'b0, id_opcode}, {25'b0, exp_instr[6:0]});
        checks++;
        if (dut.count > DEPTH) begin
            failures++;
            $display("FAIL fifo_count: got %0d expected <= %0d", dut.count, DEPTH);
        end
        fire = exp_rv && rqr;
        pop  = exp_idv && idr;
        @(posedge clk);
        #1;
        if (rsp_now) m = memq.pop_front();
        if (r) begin
            bufq.delete();
            mpc = RESET_PC;
            epoch++;
            foreach (memq[i]) memq[i].orphan = 1'b1;
        end else if (rv) begin
            bufq.delete();
            mpc = rpc;
            epoch++;
        end else begin
            if (rsp_now && !m.orphan && m.epoch == epoch)
                bufq.push_back('{pc: m.addr, instr: m.addr ^ KEY});
            if (pop) popped.push_back(bufq.pop_front().pc);
            if (fire) begin
                lat = $urandom_range(lat_max, lat_min);
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                memq.push_back('{addr: mpc, due: due, epoch: epoch, orphan: 1'b0});
                req_log.push_back(mpc);
                mpc = mpc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 20 && memq.size() != 0; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   base, lbase;
        tbl[0] = '{1, 0, 32'h0,  0, 32'h0};
        tbl[1] = '{0, 1, 32'h0,  0, 32'h0};
        tbl[2] = '{0, 1, 32'h4,  0, 32'h0};
        tbl[3] = '{0, 0, 32'h8,  1, 32'h0};
        tbl[4] = '{0, 1, 32'h8,  1, 32'h4};
        tbl[5] = '{0, 1, 32'hC,  0, 32'h0};
        tbl[6] = '{0, 0, 32'h10, 1, 32'h8};

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        @(posedge clk); @(posedge clk); #1;

        // Reset then run with a 1-cycle memory and id_ready=1.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].rst, 1'b0, 32'h0, 1'b1, 1'b1);
            chk("tbl_req_valid", {31'b0, s_rv}, {31'b0, tbl[i].exp_rv});
            chk("tbl_req_addr", s_addr, tbl[i].exp_addr);
            chk("tbl_id_valid", {31'b0, s_idv}, {31'b0, tbl[i].exp_idv});
            chk("tbl_id_pc", s_pc, tbl[i].exp_pc);
            if (i == 3) chk("tbl_first_instr", s_instr, 32'hA5A5_0000);
        end

        // Back-pressure: decode stalls for 10 cycles, then drains in order.
        lat_min = 1; lat_max = 1;
        do_reset();
        base = popped.size();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("bp_req_valid_low", {31'b0, s_rv}, 32'h0);
        chk("bp_fifo_full", {31'b0, s_idv}, 32'h1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("bp_pop0", popped[base], 32'h0);
        chk("bp_pop1", popped[base+1], 32'h4);
        chk("bp_pop2", popped[base+2], 32'h8);

        // Redirect with two fetches outstanding.
        lat_min = 3; lat_max = 3;
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        base = popped.size(); lbase = req_log.size();
        step(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
        chk("redir_drop", {30'b0, dut.drop}, 32'h2);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("redir_first_req", req_log[lbase], 32'h100);
        chk("redir_first_pop", popped[base], 32'h100);

        // Redirect coinciding with a response and an id handshake.
        lat_min = 1; lat_max = 1;
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        lbase = req_log.size();
        step(1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
        chk("same_req_valid", {31'b0, s_rv}, 32'h0);
        chk("same_pre_id_valid", {31'b0, s_idv}, 32'h1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("same_id_valid", {31'b0, s_idv}, 32'h0);
        chk("same_next_addr", req_log[lbase], 32'h200);

        // PC wrap across the top of the address space.
        base = popped.size(); lbase = req_log.size();
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap_req0", req_log[lbase], 32'hFFFF_FFFC);
        chk("wrap_req1", req_log[lbase+1], 32'h0);
        chk("wrap_pop0", popped[base], 32'hFFFF_FFFC);
        chk("wrap_pop1", popped[base+1], 32'h0);

        // Reset with two fetches in flight; their late responses must be ignored.
        lat_min = 3; lat_max = 3;
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("rst_id_valid", {31'b0, s_idv}, 32'h0);
        chk("rst_id_instr", s_instr, NOP);
        chk("rst_id_pc", s_pc, 32'h0);
        chk("rst_req_addr", s_addr, RESET_PC);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        lbase = req_log.size();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("rst_first_req", req_log[lbase], RESET_PC);

        // Randomized traffic with variable latency, stalls and redirects.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            bit          rv;
            logic [31:0] rpc;
            rv  = ($urandom_range(99, 0) < 4);
            rpc = ($urandom_range(1, 0) == 1) ? (32'hFFFF_FFF0 + ($urandom_range(3, 0) * 4))
                                              : ({$urandom} & 32'hFFFF_FFFC);
            step(1'b0, rv, rpc, $urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
